// File: rtl/seq_sub_if.sv
// Handshake/operand bundle for the bit-serial subtractor seq_sub.
// Carries the ovf flag only when SEQ_SUB_OVF_EN is defined.
interface seq_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   y;
`ifdef SEQ_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, y, ovf);
    modport slave  (input start, a, b, output busy, done, y, ovf);
`else
    modport master (output start, a, b, input busy, done, y);
    modport slave  (input start, a, b, output busy, done, y);
`endif
endinterface

// File: rtl/seq_sub.sv
// Bit-serial LSB-first subtractor: y = a - b over WIDTH cycles, start/busy/done handshake.
// Optional signed-overflow flag (ovf) enabled by defining SEQ_SUB_OVF_EN.
module seq_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_sub_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH:0]   y_q, y_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SEQ_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             load_c;
    logic             dbit_c;
    logic             bout_c;
    logic [WIDTH-1:0] diff_c;

    // One full-subtractor bit slice on the current operand LSBs.
    always_comb begin
        dbit_c = a_q[0] ^ b_q[0] ^ brw_q;
        bout_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        diff_c = {dbit_c, res_q};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef SEQ_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        load_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                load_c = bus.start;
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = diff_c[WIDTH-1:1];
                brw_d = bout_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    y_d     = {bout_c, diff_c};
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef SEQ_SUB_OVF_EN
                    // Operands' MSBs are in bit 0 on the final slice.
                    ovf_d   = (a_q[0] != b_q[0]) && (dbit_c != a_q[0]);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // A start on the edge that leaves DONE begins the next op: WIDTH+1 cycle throughput.
                load_c  = bus.start;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_c) begin
            a_d     = bus.a;
            b_d     = bus.b;
            res_d   = '0;
            cnt_d   = '0;
            brw_d   = 1'b0;
            state_d = S_SHIFT;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SEQ_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
`ifdef SEQ_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub.sv
// Scoreboard bench for seq_sub: expected results queued at issue, compared on done.
module tb_seq_sub;
    localparam int unsigned W = 4;

    typedef struct {
        logic [W:0] y;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_sub_if #(.WIDTH(W)) bus ();
    seq_sub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        exp_t e;
        int   sa;
        int   sb;
        int   sd;
        sa    = $signed(a);
        sb    = $signed(b);
        sd    = sa - sb;
        e.y   = {1'b0, a} - {1'b0, b};
        e.ovf = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        e.cyc = c;
        return e;
    endfunction

    // Compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("y", 32'(bus.y), 32'(mon_e.y));
                check("done_cycle", cyc, mon_e.cyc);
`ifdef SEQ_SUB_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    // Called at a negedge with the DUT idle; start is sampled at the next posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sbq.push_back(model(a, b, cyc + 1 + int'(W)));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || sbq.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 40), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic op with explicit handshake timing.
        issue(4'd9, 4'd3);
        check("busy_at_n", 32'(bus.busy), 32'd1);
        repeat (W - 1) @(negedge clk);
        check("done_early", 32'(bus.done), 32'd0);
        check("y_hold_shift", 32'(bus.y), 32'd0);
        check("busy_mid", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("done_at_n4", 32'(bus.done), 32'd1);
        check("busy_at_n4", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("done_n5", 32'(bus.done), 32'd0);
        check("busy_n5", 32'(bus.busy), 32'd0);
        check("y_held", 32'(bus.y), 32'h06);

        issue(4'd3, 4'd5);   wait_idle();
        issue(4'd0, 4'd15);  wait_idle();
        issue(4'd15, 4'd15); wait_idle();

        // Start held high: one op per W+1 cycles, nothing queued.
        bus.a     = 4'd12;
        bus.b     = 4'd4;
        bus.start = 1'b1;
        sbq.push_back(model(4'd12, 4'd4, cyc + 1 + int'(W)));
        sbq.push_back(model(4'd12, 4'd4, cyc + 1 + 2 * int'(W) + 1));
        repeat (2 * W + 2) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Operands changed mid-operation have no effect.
        issue(4'd7, 4'd2);
        @(negedge clk);
        bus.a = 4'd1;
        bus.b = 4'd1;
        wait_idle();

        // Reset mid-operation aborts with no done.
        issue(4'd10, 4'd3);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_y", 32'(bus.y), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        issue(4'd5, 4'd5); wait_idle();

        // Signed-overflow corner cases (y is checked in every build).
        issue(4'b1000, 4'b0001); wait_idle();
        issue(4'b0111, 4'b1111); wait_idle();
        issue(4'd9, 4'd3);       wait_idle();

        repeat (10) begin
            issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            wait_idle();
        end

        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
